instr_fetch_unit: RTL and testbench

Instruction-issue front end that drives the mipscpu datapath's instrword/newinstr input pair. It holds the PC and a loadable instruction memory, and presents each instruction word stable before pulsing newinstr. It then waits a fixed execution window and computes the next PC, handling sequential flow, beq/bne (using a zero flag returned by the datapath) and j.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/instr_fetch_unit_if.sv | 25 ++
 rtl/next_pc_calc.sv | 30 +++
 rtl/instr_fetch_unit.sv | 118 +++++++++++
 tb/tb_instr_fetch_unit.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch front end: opcodes, halt marker, FSM states.
package fetch_pkg;

    localparam logic [5:0]  OP_J      = 6'd2;
    localparam logic [5:0]  OP_BEQ    = 6'd4;
    localparam logic [5:0]  OP_BNE    = 6'd5;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_EXEC   = 3'd4,
        ST_NEXT   = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Issue/load bus between the fetch unit (master) and the host plus datapath side (slave).
interface instr_fetch_unit_if #(
    parameter int IDX_W = 6
);
    logic             start;
    logic             ld_en;
    logic [IDX_W-1:0] ld_addr;
    logic [31:0]      ld_data;
    logic             zero;
    logic [31:0]      instrword;
    logic             newinstr;
    logic [31:0]      pc;
    logic             busy;
    logic             halted;

    modport master (
        input  start, ld_en, ld_addr, ld_data, zero,
        output instrword, newinstr, pc, busy, halted
    );

    modport slave (
        output start, ld_en, ld_addr, ld_data, zero,
        input  instrword, newinstr, pc, busy, halted
    );
endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC for sequential flow, beq/bne and j; used in the NEXT state.
module next_pc_calc
    import fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instrword,
    input  logic        zero_q,
    output logic [31:0] next_pc
);

    logic [5:0]  op;
    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] j_target;

    assign op        = instrword[31:26];
    assign pc_plus4  = pc + 32'd4;
    assign br_target = pc_plus4 + {{14{instrword[15]}}, instrword[15:0], 2'b00};
    assign j_target  = {pc_plus4[31:28], instrword[25:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if ((op == OP_BEQ && zero_q) || (op == OP_BNE && !zero_q)) begin
            next_pc = br_target;
        end else if (op == OP_J) begin
            next_pc = j_target;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Holds PC and loadable imem; presents each word one cycle before a newinstr pulse,
// then waits EXEC_CYCLES and computes the next PC (period EXEC_CYCLES+4); loads/start only when idle or halted.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          IMEM_DEPTH  = 64,
    parameter int          IDX_W       = 6,
    parameter int          EXEC_CYCLES = 8,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
)(
    input  logic               clk,
    input  logic               rst,
    instr_fetch_unit_if.master bus
);

    localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

    logic [31:0] imem [IMEM_DEPTH];

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      iw_q, iw_d;
    logic             newinstr_q, newinstr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             zero_q, zero_d;
    logic             mem_we;
    logic [31:0]      next_pc;

    next_pc_calc u_next_pc (
        .pc        (pc_q),
        .instrword (iw_q),
        .zero_q    (zero_q),
        .next_pc   (next_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            iw_q       <= '0;
            newinstr_q <= 1'b0;
            cnt_q      <= '0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            iw_q       <= iw_d;
            newinstr_q <= newinstr_d;
            cnt_q      <= cnt_d;
            zero_q     <= zero_d;
        end
    end

    // Memory contents survive reset so a program can be reloaded-free after abort.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            imem[bus.ld_addr] <= bus.ld_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        iw_d       = iw_q;
        newinstr_d = 1'b0;
        cnt_d      = cnt_q;
        zero_d     = zero_q;
        mem_we     = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                mem_we = bus.ld_en;
                if (bus.start) begin
                    pc_d    = RESET_PC;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                iw_d    = imem[pc_q[IDX_W+1:2]];
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (iw_q == HALT_WORD) begin
                    state_d = ST_HALT;
                end else begin
                    newinstr_d = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = CNT_W'(EXEC_CYCLES - 1);
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    zero_d  = bus.zero;
                    state_d = ST_NEXT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_NEXT: begin
                pc_d    = next_pc;
                state_d = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.instrword = iw_q;
    assign bus.newinstr  = newinstr_q;
    assign bus.pc        = pc_q;
    assign bus.halted    = (state_q == ST_HALT);
    assign bus.busy      = (state_q == ST_FETCH) || (state_q == ST_SETTLE) ||
                           (state_q == ST_ISSUE) || (state_q == ST_EXEC)   ||
                           (state_q == ST_NEXT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed plus random program runs of instr_fetch_unit against a PC-level reference model.
module tb_instr_fetch_unit;

    localparam logic [31:0] HALTW  = 32'hFFFF_FFFF;
    localparam int          PERIOD = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_unit_if #(.IDX_W(6)) bus ();

    instr_fetch_unit #(
        .IMEM_DEPTH  (64),
        .IDX_W       (6),
        .EXEC_CYCLES (8),
        .RESET_PC    (32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] mem [64];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        total++;
        assert (obs === expd) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expd);
        end
    endtask

    function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] w, input logic z);
        int unsigned op;
        logic [31:0] seq;
        int          off;
        op  = w >> 26;
        seq = p + 32'd4;
        off = $signed(w[15:0]) * 4;
        if ((op == 4 && z) || (op == 5 && !z)) return seq + off;
        if (op == 2) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 4);
        return seq;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load(input int idx, input logic [31:0] d);
        bus.ld_en   = 1'b1;
        bus.ld_addr = idx[5:0];
        bus.ld_data = d;
        @(negedge clk);
        bus.ld_en = 1'b0;
        mem[idx]  = d;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_pulse(input int maxc, output bit got, output int cyc, output logic [31:0] prev_iw);
        got     = 1'b0;
        cyc     = 0;
        prev_iw = bus.instrword;
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            if (bus.newinstr) begin
                got = 1'b1;
                cyc = c;
                break;
            end
            prev_iw = bus.instrword;
        end
    endtask

    task automatic wait_halt(input string tag, input logic [31:0] exp_pc);
        int pulses;
        pulses = 0;
        for (int c = 0; c < 40 && !bus.halted; c++) begin
            @(negedge clk);
            if (bus.newinstr) pulses++;
        end
        check({tag, "_halted"}, {31'b0, bus.halted}, 32'd1);
        check({tag, "_halt_pc"}, bus.pc, exp_pc);
        check({tag, "_halt_nopulse"}, pulses, 32'd0);
        check({tag, "_halt_notbusy"}, {31'b0, bus.busy}, 32'd0);
    endtask

    // Follows the program from RESET_PC; returns on halt or right after the n-th pulse.
    task automatic run_prog(input string tag, input int n, input int zmode);
        logic [31:0] mpc, w, piw;
        bit          got;
        int          cyc;
        logic        z;
        mpc = 32'h0;
        for (int k = 0; k < n; k++) begin
            w = mem[mpc[7:2]];
            if (w == HALTW) begin
                wait_halt(tag, mpc);
                check({tag, "_halt_iw"}, bus.instrword, HALTW);
                return;
            end
            wait_pulse(40, got, cyc, piw);
            check({tag, "_pulse_seen"}, {31'b0, got}, 32'd1);
            if (!got) return;
            if (k > 0) check({tag, "_period"}, cyc, PERIOD);
            check({tag, "_pc"}, bus.pc, mpc);
            check({tag, "_iw"}, bus.instrword, w);
            check({tag, "_iw_stable"}, piw, w);
            z = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
            bus.zero = z;
            mpc = ref_next(mpc, w, z);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w;
        bit          got;
        int          cyc;
        logic [31:0] piw;

        bus.start = 1'b0; bus.ld_en = 1'b0; bus.ld_addr = '0; bus.ld_data = '0; bus.zero = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;

        repeat (2) @(negedge clk);
        check("rst_pc", bus.pc, 32'h0);
        check("rst_iw", bus.instrword, 32'h0);
        check("rst_newinstr", {31'b0, bus.newinstr}, 32'd0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_halted", {31'b0, bus.halted}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", {31'b0, bus.busy}, 32'd0);

        // sequential issue then halt at pc 8
        load(0, 32'h012A_4020); load(1, 32'h8D09_0004); load(2, HALTW);
        pulse_start();
        run_prog("seq", 4, 0);

        do_reset(); load(0, 32'h1000_0003); load(4, HALTW);
        pulse_start(); run_prog("beq_t", 3, 1);
        do_reset(); load(1, HALTW);
        pulse_start(); run_prog("beq_nt", 3, 0);
        do_reset(); load(0, 32'h1400_0003);
        pulse_start(); run_prog("bne_t", 3, 0);
        do_reset(); load(0, 32'h0800_0005); load(5, HALTW);
        pulse_start(); run_prog("jump", 3, 0);

        // 0 -> 0xFC (index 63) -> 0x100 (index 0); then reset while newinstr is high
        do_reset(); load(0, 32'h0800_003F); load(63, 32'h0000_0000);
        pulse_start(); run_prog("wrap", 3, 0);
        #2 rst = 1'b1;
        #1;
        check("rst_issue_newinstr", {31'b0, bus.newinstr}, 32'd0);
        check("rst_issue_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_issue_pc", bus.pc, 32'h0);
        check("rst_issue_iw", bus.instrword, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // load and start during EXEC are ignored
        load(0, 32'h012A_4020); load(1, HALTW);
        pulse_start();
        wait_pulse(40, got, cyc, piw);
        check("guard_pulse_seen", {31'b0, got}, 32'd1);
        @(negedge clk);
        bus.ld_en = 1'b1; bus.ld_addr = 6'd0; bus.ld_data = 32'hDEAD_BEEF; bus.start = 1'b1;
        @(negedge clk);
        bus.ld_en = 1'b0; bus.start = 1'b0;
        wait_halt("guard", 32'h4);
        pulse_start(); run_prog("guard_rerun", 3, 0);

        // load with start in HALT: new word at index 0 is the one fetched
        bus.ld_en = 1'b1; bus.ld_addr = 6'd0; bus.ld_data = 32'h2000_0000; bus.start = 1'b1;
        @(negedge clk);
        bus.ld_en = 1'b0; bus.start = 1'b0;
        mem[0] = 32'h2000_0000;
        run_prog("ld_start", 3, 0);

        // random program with random zero flags, then reset inside EXEC
        do_reset();
        for (int i = 0; i < 64; i++) begin
            case ($urandom_range(0, 3))
                0: w = {6'd4, 10'($urandom), 16'($urandom)};
                1: w = {6'd5, 10'($urandom), 16'($urandom)};
                2: w = {6'd2, 26'($urandom)};
                default: w = {6'h08, 26'($urandom)};
            endcase
            load(i, w);
        end
        pulse_start(); run_prog("rnd", 25, 2);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_exec_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_exec_pc", bus.pc, 32'h0);
        check("rst_exec_iw", bus.instrword, 32'h0);
        check("rst_exec_newinstr", {31'b0, bus.newinstr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
